gp_trig_cfg_bank: RTL and testbench

//  Parametrised trigger-configuration register bank for the gp_engine; successor to the fixed 4-source bank.

---
 rtl/gp_trig_cfg_bank.sv | 145 ++++++++++++++
 tb/tb_gp_trig_cfg_bank.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gp_trig_cfg_bank.sv
// Trigger-configuration bank: double-buffered staging/active configs with commit, lock,
// error reporting and a registered single-beat read response.
module gp_trig_cfg_bank #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned TRANS_ADDR_WIDTH = 8,
  parameter int unsigned NUM_TRIG         = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  input  logic                           reg_en,
  input  logic [TRANS_ADDR_WIDTH-1:0]    trans_addr,
  input  logic                           slv_o_valid,
  input  logic                           slv_i_rd0_wr1,
  input  logic [DATA_WIDTH-1:0]          slv_i_wr_data,
  input  logic [DATA_WIDTH/8-1:0]        slv_i_wr_strb,
  output logic                           slv_i_ready,
  output logic [DATA_WIDTH-1:0]          slv_o_read_data,
  output logic                           slv_o_rd_valid,
  output logic                           slv_o_err,
  input  logic                           reg_rd_en,
  output logic [NUM_TRIG*DATA_WIDTH-1:0] rd_trig_config,
  output logic                           reg_rd_valid,
  output logic                           commit_pending
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned IdxW  = TRANS_ADDR_WIDTH - 2;
  localparam logic [TRANS_ADDR_WIDTH-1:0] AddrCtrl   = TRANS_ADDR_WIDTH'(8'hF0);
  localparam logic [TRANS_ADDR_WIDTH-1:0] AddrStatus = TRANS_ADDR_WIDTH'(8'hF4);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e                      state_q;
  logic [DATA_WIDTH-1:0]       staging_q [NUM_TRIG];
  logic [DATA_WIDTH-1:0]       active_q  [NUM_TRIG];
  logic [DATA_WIDTH-1:0]       rd_data_q;
  logic                        rd_valid_q, err_q;
  logic                        pending_q, lock_q, err_sticky_q;
  logic [NUM_TRIG*DATA_WIDTH-1:0] snap_q;
  logic                        snap_valid_q;

  logic [NUM_TRIG-1:0]   cfg_sel;
  logic                  cfg_hit, ctrl_hit, status_hit, addr_ok;
  logic                  acc, rd_acc, wr_acc, rd_err, wr_err, do_copy;
  logic [DATA_WIDTH-1:0] rd_mux, wmask;

  always_comb begin
    cfg_sel = '0;
    rd_mux  = '0;
    wmask   = '0;
    for (int i = 0; i < int'(NUM_TRIG); i++) begin
      if (trans_addr[1:0] == 2'b00 && trans_addr[TRANS_ADDR_WIDTH-1:2] == IdxW'(i)) begin
        cfg_sel[i] = 1'b1;
      end
    end
    ctrl_hit   = (trans_addr == AddrCtrl);
    status_hit = (trans_addr == AddrStatus);
    cfg_hit    = |cfg_sel;
    addr_ok    = cfg_hit | ctrl_hit | status_hit;
    for (int i = 0; i < int'(NUM_TRIG); i++) begin
      if (cfg_sel[i]) rd_mux = staging_q[i];
    end
    // CTRL is write-only and reads back as zero without an error
    if (status_hit) rd_mux = DATA_WIDTH'({err_sticky_q, lock_q, pending_q});
    for (int b = 0; b < int'(StrbW); b++) begin
      wmask[8*b +: 8] = {8{slv_i_wr_strb[b]}};
    end
    acc     = reg_en & slv_o_valid & (state_q == StIdle);
    rd_acc  = acc & ~slv_i_rd0_wr1;
    wr_acc  = acc & slv_i_rd0_wr1;
    rd_err  = ~addr_ok;
    wr_err  = ~addr_ok | (cfg_hit & lock_q);
    // active must stay frozen while the FSM is snapshotting it
    do_copy = pending_q & ~reg_rd_en;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= StIdle;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      err_q        <= 1'b0;
      pending_q    <= 1'b0;
      lock_q       <= 1'b0;
      err_sticky_q <= 1'b0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      for (int i = 0; i < int'(NUM_TRIG); i++) begin
        staging_q[i] <= '0;
        active_q[i]  <= '0;
      end
    end else begin
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      err_q        <= 1'b0;
      snap_valid_q <= reg_rd_en;
      if (reg_rd_en) begin
        for (int i = 0; i < int'(NUM_TRIG); i++) begin
          snap_q[i*DATA_WIDTH +: DATA_WIDTH] <= active_q[i];
        end
      end
      if (do_copy) begin
        for (int i = 0; i < int'(NUM_TRIG); i++) active_q[i] <= staging_q[i];
        pending_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (rd_acc) begin
            state_q    <= StResp;
            rd_valid_q <= 1'b1;
            rd_data_q  <= rd_mux;
            err_q      <= rd_err;
            if (rd_err) err_sticky_q <= 1'b1;
          end else if (wr_acc) begin
            err_q <= wr_err;
            if (wr_err) begin
              err_sticky_q <= 1'b1;
            end else begin
              if (status_hit) err_sticky_q <= 1'b0;
              // a commit landing on the copy edge re-arms pending for the newer staging
              if (ctrl_hit && slv_i_wr_strb[0]) begin
                if (slv_i_wr_data[0]) pending_q <= 1'b1;
                if (slv_i_wr_data[1]) lock_q    <= 1'b1;
              end
              for (int i = 0; i < int'(NUM_TRIG); i++) begin
                if (cfg_sel[i]) staging_q[i] <= (staging_q[i] & ~wmask) | (slv_i_wr_data & wmask);
              end
            end
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign slv_i_ready     = (state_q == StIdle);
  assign slv_o_read_data = rd_data_q;
  assign slv_o_rd_valid  = rd_valid_q;
  assign slv_o_err       = err_q;
  assign rd_trig_config  = snap_q;
  assign reg_rd_valid    = snap_valid_q;
  assign commit_pending  = pending_q;

endmodule

// File: tb/tb_gp_trig_cfg_bank.sv
// Self-checking bench for gp_trig_cfg_bank (8 trigger slots) against a per-edge
// behavioural model built from the register map and commit/snapshot rules.
module tb_gp_trig_cfg_bank;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NT = 8;

  logic            i_clk = 1'b0;
  logic            i_rstn = 1'b0;
  logic            reg_en = 1'b0;
  logic [AW-1:0]   trans_addr = '0;
  logic            slv_o_valid = 1'b0;
  logic            slv_i_rd0_wr1 = 1'b0;
  logic [DW-1:0]   slv_i_wr_data = '0;
  logic [DW/8-1:0] slv_i_wr_strb = '0;
  logic            slv_i_ready;
  logic [DW-1:0]   slv_o_read_data;
  logic            slv_o_rd_valid;
  logic            slv_o_err;
  logic            reg_rd_en = 1'b0;
  logic [NT*DW-1:0] rd_trig_config;
  logic            reg_rd_valid;
  logic            commit_pending;

  gp_trig_cfg_bank #(.DATA_WIDTH(DW), .TRANS_ADDR_WIDTH(AW), .NUM_TRIG(NT)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .reg_en(reg_en), .trans_addr(trans_addr),
    .slv_o_valid(slv_o_valid), .slv_i_rd0_wr1(slv_i_rd0_wr1), .slv_i_wr_data(slv_i_wr_data),
    .slv_i_wr_strb(slv_i_wr_strb), .slv_i_ready(slv_i_ready),
    .slv_o_read_data(slv_o_read_data), .slv_o_rd_valid(slv_o_rd_valid), .slv_o_err(slv_o_err),
    .reg_rd_en(reg_rd_en), .rd_trig_config(rd_trig_config), .reg_rd_valid(reg_rd_valid),
    .commit_pending(commit_pending)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;

  // Reference model
  logic [DW-1:0]    m_stage [NT];
  logic [DW-1:0]    m_active [NT];
  logic             m_pending, m_lock, m_sticky, m_busy;
  logic [NT*DW-1:0] m_snap;
  logic             exp_rd_valid, exp_err, exp_snap_valid;
  logic [DW-1:0]    exp_rd_data;

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      m_stage[i] = '0;
      m_active[i] = '0;
    end
    m_pending = 0; m_lock = 0; m_sticky = 0; m_busy = 0; m_snap = '0;
    exp_rd_valid = 0; exp_err = 0; exp_snap_valid = 0; exp_rd_data = '0;
  endtask

  // Predict the effect of the coming clock edge from the current inputs, then take the edge.
  task automatic step();
    logic [DW-1:0] old_stage [NT];
    logic acc, pend0, lock0, stk0, cfg, ctrl, stat, valid_addr, werr;
    int idx;
    for (int i = 0; i < NT; i++) old_stage[i] = m_stage[i];
    pend0 = m_pending; lock0 = m_lock; stk0 = m_sticky;
    acc = reg_en && slv_o_valid && !m_busy;
    exp_rd_valid = 0; exp_rd_data = '0; exp_err = 0;
    exp_snap_valid = reg_rd_en;
    if (reg_rd_en) for (int i = 0; i < NT; i++) m_snap[i*DW +: DW] = m_active[i];
    if (pend0 && !reg_rd_en) begin
      for (int i = 0; i < NT; i++) m_active[i] = old_stage[i];
      m_pending = 0;
    end
    idx = int'(trans_addr) / 4;
    cfg = (int'(trans_addr) % 4 == 0) && (idx < NT);
    ctrl = (trans_addr == 8'hF0);
    stat = (trans_addr == 8'hF4);
    valid_addr = cfg || ctrl || stat;
    if (m_busy) begin
      m_busy = 0;
    end else if (acc && !slv_i_rd0_wr1) begin
      m_busy = 1;
      exp_rd_valid = 1;
      exp_err = !valid_addr;
      if (cfg) exp_rd_data = old_stage[idx];
      else if (stat) exp_rd_data = {29'd0, stk0, lock0, pend0};
      if (!valid_addr) m_sticky = 1;
    end else if (acc) begin
      werr = !valid_addr || (cfg && lock0);
      exp_err = werr;
      if (werr) m_sticky = 1;
      else if (cfg) begin
        for (int b = 0; b < DW / 8; b++)
          if (slv_i_wr_strb[b]) m_stage[idx][8*b +: 8] = slv_i_wr_data[8*b +: 8];
      end else if (ctrl && slv_i_wr_strb[0]) begin
        if (slv_i_wr_data[0]) m_pending = 1;
        if (slv_i_wr_data[1]) m_lock = 1;
      end else if (stat) m_sticky = 0;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_idle();
    reg_en = 0; slv_o_valid = 0; slv_i_rd0_wr1 = 0; trans_addr = '0;
    slv_i_wr_data = '0; slv_i_wr_strb = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    reg_en = 1; slv_o_valid = 1; slv_i_rd0_wr1 = 1; trans_addr = a;
    slv_i_wr_data = d; slv_i_wr_strb = s;
    step();
    drive_idle();
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    reg_en = 1; slv_o_valid = 1; slv_i_rd0_wr1 = 0; trans_addr = a;
    step();
    drive_idle();
  endtask

  task automatic apply_reset();
    drive_idle();
    reg_rd_en = 0;
    i_rstn = 0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (slv_i_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", slv_i_ready); end
    total++; if (slv_o_rd_valid !== 1'b0 || slv_o_err !== 1'b0 || reg_rd_valid !== 1'b0) begin
      bad++; $display("FAIL reset_pulses got=%b%b%b want=000", slv_o_rd_valid, slv_o_err, reg_rd_valid); end
    total++; if (rd_trig_config !== '0 || commit_pending !== 1'b0) begin
      bad++; $display("FAIL reset_state cfg=%h pend=%0b want zero", rd_trig_config, commit_pending); end
    do_read(8'h00);
    total++; if (slv_o_rd_valid !== 1'b1 || slv_i_ready !== 1'b0 || slv_o_read_data !== 32'h0) begin
      bad++; $display("FAIL first_read vld=%0b rdy=%0b data=%h want 1 0 0", slv_o_rd_valid, slv_i_ready, slv_o_read_data); end
    step();
    total++; if (slv_o_rd_valid !== 1'b0 || slv_i_ready !== 1'b1) begin
      bad++; $display("FAIL read_end vld=%0b rdy=%0b want 0 1", slv_o_rd_valid, slv_i_ready); end
  endtask

  task automatic test_strobe_write();
    do_write(8'h04, 32'hDEADBEEF, 4'b0011);
    total++; if (slv_o_err !== 1'b0) begin bad++; $display("FAIL strb_write_err got=%0b want=0", slv_o_err); end
    do_read(8'h04);
    total++; if (slv_o_read_data !== 32'h0000BEEF) begin
      bad++; $display("FAIL strb_readback got=%h want=0000beef", slv_o_read_data); end
    step();
    reg_rd_en = 1; step(); reg_rd_en = 0;
    total++; if (reg_rd_valid !== 1'b1 || rd_trig_config[63:32] !== 32'h0) begin
      bad++; $display("FAIL precommit_snap vld=%0b cfg1=%h want 1 0", reg_rd_valid, rd_trig_config[63:32]); end
  endtask

  task automatic test_commit_deferred();
    reg_rd_en = 1;
    do_write(8'hF0, 32'h1, 4'hF);
    for (int c = 0; c < 2; c++) begin
      step();
      total++; if (commit_pending !== 1'b1 || rd_trig_config[63:32] !== 32'h0) begin
        bad++; $display("FAIL deferred_commit pend=%0b cfg1=%h want 1 0", commit_pending, rd_trig_config[63:32]); end
    end
    reg_rd_en = 0; step();
    total++; if (commit_pending !== 1'b0) begin bad++; $display("FAIL commit_applied pend=%0b want 0", commit_pending); end
    reg_rd_en = 1; step(); reg_rd_en = 0;
    total++; if (rd_trig_config[63:32] !== 32'h0000BEEF || rd_trig_config !== m_snap) begin
      bad++; $display("FAIL committed_snap cfg1=%h want 0000beef", rd_trig_config[63:32]); end
    step();
  endtask

  task automatic test_lock();
    do_write(8'hF0, 32'h2, 4'hF);
    do_write(8'h00, 32'h1, 4'hF);
    total++; if (slv_o_err !== 1'b1) begin bad++; $display("FAIL locked_write_err got=%0b want=1", slv_o_err); end
    step();
    total++; if (slv_o_err !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%0b want=0", slv_o_err); end
    do_read(8'h00);
    total++; if (slv_o_read_data !== 32'h0) begin bad++; $display("FAIL locked_staging got=%h want=0", slv_o_read_data); end
    step();
    do_read(8'hF4);
    total++; if (slv_o_read_data !== 32'h6) begin bad++; $display("FAIL status_locked got=%h want=6", slv_o_read_data); end
    step();
  endtask

  task automatic test_invalid();
    apply_reset();
    do_read(8'h80);
    total++; if (slv_o_read_data !== 32'h0 || slv_o_err !== 1'b1 || slv_o_rd_valid !== 1'b1) begin
      bad++; $display("FAIL invalid_read data=%h err=%0b vld=%0b want 0 1 1", slv_o_read_data, slv_o_err, slv_o_rd_valid); end
    step();
    do_write(8'hF4, 32'h0, 4'hF);
    total++; if (slv_o_err !== 1'b0) begin bad++; $display("FAIL status_write_err got=%0b want=0", slv_o_err); end
    do_read(8'hF4);
    total++; if (slv_o_read_data !== 32'h0) begin bad++; $display("FAIL status_cleared got=%h want=0", slv_o_read_data); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vals [NT];
    apply_reset();
    reg_en = 1; slv_o_valid = 1; slv_i_rd0_wr1 = 1; slv_i_wr_strb = 4'hF;
    for (int i = 0; i < NT; i++) begin
      vals[i] = $urandom;
      trans_addr = 8'(4 * i);
      slv_i_wr_data = vals[i];
      step();
      total++; if (slv_o_err !== 1'b0 || slv_i_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_write%0d err=%0b rdy=%0b want 0 1", i, slv_o_err, slv_i_ready); end
    end
    drive_idle();
    for (int i = 0; i < NT; i++) begin
      do_read(8'(4 * i));
      total++; if (slv_o_read_data !== vals[i]) begin
        bad++; $display("FAIL b2b_read%0d got=%h want=%h", i, slv_o_read_data, vals[i]); end
      step();
    end
  endtask

  task automatic test_top_slot();
    apply_reset();
    do_write(8'h1C, 32'hA5, 4'hF);
    do_write(8'hF0, 32'h1, 4'hF);
    step();
    reg_rd_en = 1; step(); reg_rd_en = 0;
    total++; if (rd_trig_config[255:224] !== 32'hA5 || reg_rd_valid !== 1'b1) begin
      bad++; $display("FAIL top_slot cfg7=%h vld=%0b want a5 1", rd_trig_config[255:224], reg_rd_valid); end
    do_read(8'h1C);
    i_rstn = 0;
    #1;
    total++; if (slv_o_rd_valid !== 1'b0 || slv_i_ready !== 1'b1 || slv_o_read_data !== 32'h0 ||
                 rd_trig_config !== '0 || reg_rd_valid !== 1'b0) begin
      bad++; $display("FAIL reset_in_resp vld=%0b rdy=%0b data=%h cfg7=%h want 0 1 0 0",
                      slv_o_rd_valid, slv_i_ready, slv_o_read_data, rd_trig_config[255:224]); end
    apply_reset();
    step();
    total++; if (slv_o_rd_valid !== 1'b0 || slv_o_err !== 1'b0 || commit_pending !== 1'b0) begin
      bad++; $display("FAIL post_reset vld=%0b err=%0b pend=%0b want 0 0 0", slv_o_rd_valid, slv_o_err, commit_pending); end
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      reg_en = ($urandom % 10) < 8;
      slv_o_valid = ($urandom % 10) < 7;
      slv_i_rd0_wr1 = $urandom % 2;
      slv_i_wr_data = $urandom;
      slv_i_wr_strb = 4'($urandom);
      reg_rd_en = ($urandom % 4) == 0;
      r = $urandom % 10;
      if (r < 6) trans_addr = 8'(4 * ($urandom % NT));
      else if (r == 6) trans_addr = 8'hF0;
      else if (r == 7) trans_addr = 8'hF4;
      else if (r == 8) trans_addr = 8'($urandom);
      else trans_addr = 8'(4 * (NT + $urandom % 8));
      if (trans_addr == 8'hF0 && ($urandom % 20) != 0) slv_i_wr_data[1] = 1'b0;
      step();
      total++; if (slv_i_ready !== !m_busy) begin bad++; $display("FAIL rnd_ready c=%0d got=%0b want=%0b", c, slv_i_ready, !m_busy); end
      total++; if (slv_o_rd_valid !== exp_rd_valid) begin bad++; $display("FAIL rnd_rd_valid c=%0d got=%0b want=%0b", c, slv_o_rd_valid, exp_rd_valid); end
      total++; if (slv_o_read_data !== exp_rd_data) begin bad++; $display("FAIL rnd_rd_data c=%0d got=%h want=%h", c, slv_o_read_data, exp_rd_data); end
      total++; if (slv_o_err !== exp_err) begin bad++; $display("FAIL rnd_err c=%0d got=%0b want=%0b", c, slv_o_err, exp_err); end
      total++; if (commit_pending !== m_pending) begin bad++; $display("FAIL rnd_pending c=%0d got=%0b want=%0b", c, commit_pending, m_pending); end
      total++; if (reg_rd_valid !== exp_snap_valid) begin bad++; $display("FAIL rnd_snap_valid c=%0d got=%0b want=%0b", c, reg_rd_valid, exp_snap_valid); end
      total++; if (rd_trig_config !== m_snap) begin bad++; $display("FAIL rnd_snap c=%0d got=%h want=%h", c, rd_trig_config, m_snap); end
    end
    drive_idle();
    reg_rd_en = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_strobe_write();
    test_commit_deferred();
    test_lock();
    test_invalid();
    test_back_to_back();
    test_top_slot();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
